// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - RV32I opcodes, instruction classes and decode record for the dual-issue scheduler
package sched_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ALU,
        LOAD,
        STORE,
        CTRL,
        UPPER,
        NONE
    } instr_class_e;

    typedef struct packed {
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic         writes_rd;
        logic         reads_rs1;
        logic         reads_rs2;
        instr_class_e cls;
        logic         valid;
    } decode_t;

    function automatic logic is_lsu(input instr_class_e cls);
        return (cls == LOAD) || (cls == STORE);
    endfunction

endpackage

// File: rtl/sched_decode.sv
// rtl/sched_decode.sv - combinational RV32I register-field decode for one issue slot
module sched_decode
    import sched_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic wr;
    logic r1;
    logic r2;
    instr_class_e cls;

    always_comb begin
        wr  = 1'b0;
        r1  = 1'b0;
        r2  = 1'b0;
        cls = NONE;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin cls = UPPER; wr = 1'b1; end
            OPC_JAL:            begin cls = CTRL;  wr = 1'b1; end
            OPC_JALR:           begin cls = CTRL;  wr = 1'b1; r1 = 1'b1; end
            OPC_BRANCH:         begin cls = CTRL;  r1 = 1'b1; r2 = 1'b1; end
            OPC_LOAD:           begin cls = LOAD;  wr = 1'b1; r1 = 1'b1; end
            OPC_STORE:          begin cls = STORE; r1 = 1'b1; r2 = 1'b1; end
            OPC_OP_IMM:         begin cls = ALU;   wr = 1'b1; r1 = 1'b1; end
            OPC_OP:             begin cls = ALU;   wr = 1'b1; r1 = 1'b1; r2 = 1'b1; end
            default:            ;
        endcase
    end

    // x0 is folded out here so no downstream hazard check has to special-case it
    always_comb begin
        dec.rd        = instr[11:7];
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.writes_rd = wr & (instr[11:7] != 5'd0);
        dec.reads_rs1 = r1 & (instr[19:15] != 5'd0);
        dec.reads_rs2 = r2 & (instr[24:20] != 5'd0);
        dec.cls       = cls;
        dec.valid     = |instr;
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - two-slot issue stage with load scoreboard; SCHED_STATS_EN adds perf counters
module dual_issue_scheduler
    import sched_pkg::*;
#(
    parameter int LOAD_LAT   = 2,
    parameter int DUAL_ISSUE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        nothing_filled,
    input  logic [31:0] instruction0,
    input  logic [31:0] instruction1,
    input  logic        ex_stall,
    output logic        freeze1,
    output logic        freeze2,
    output logic        dependency_on_ins2,
    output logic        issue0_valid,
    output logic [31:0] issue0_instr,
    output logic        issue1_valid,
    output logic [31:0] issue1_instr,
    output logic [31:0] stat_pairs,
    output logic [31:0] stat_singles,
    output logic [31:0] stat_stalls
);

    localparam int CW = $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(LOAD_LAT);

    decode_t d0;
    decode_t d1;

    sched_decode u_dec0 (.instr(instruction0), .dec(d0));
    sched_decode u_dec1 (.instr(instruction1), .dec(d1));

    logic [CW-1:0] sb [32];
    logic [31:0]   busy;
    logic v0, v1, hz0, raw01, busy1, pair_block;
    logic issue0, issue1, set0, set1;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            busy[i] = (sb[i] != '0);
        end
    end

    assign v0    = d0.valid & ~nothing_filled;
    assign v1    = d1.valid & ~nothing_filled;
    assign hz0   = (d0.reads_rs1 & busy[d0.rs1]) | (d0.reads_rs2 & busy[d0.rs2]);
    assign raw01 = d0.writes_rd & ((d1.reads_rs1 & (d1.rs1 == d0.rd)) |
                                   (d1.reads_rs2 & (d1.rs2 == d0.rd)));
    assign busy1 = (d1.reads_rs1 & busy[d1.rs1]) | (d1.reads_rs2 & busy[d1.rs2]);

    assign pair_block = raw01 | busy1 | (is_lsu(d0.cls) & is_lsu(d1.cls)) |
                        (d0.cls == CTRL) | ~v1 | (DUAL_ISSUE == 0);

    assign freeze2            = ex_stall;
    assign freeze1            = ex_stall | (v0 & hz0);
    assign dependency_on_ins2 = ~freeze1 & v0 & pair_block;

    assign issue0 = ~ex_stall & v0 & ~hz0;
    assign issue1 = issue0 & ~pair_block;
    assign set0   = issue0 & (d0.cls == LOAD) & d0.writes_rd;
    assign set1   = issue1 & (d1.cls == LOAD) & d1.writes_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue0_valid <= 1'b0;
            issue1_valid <= 1'b0;
            issue0_instr <= '0;
            issue1_instr <= '0;
        end else if (en && !ex_stall) begin
            issue0_valid <= issue0;
            issue1_valid <= issue1;
            issue0_instr <= instruction0;
            issue1_instr <= instruction1;
        end
    end

    // A fresh load reloads the counter even if it is still draining from an older load
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) sb[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < 32; i++) begin
                if ((set0 && d0.rd == 5'(i)) || (set1 && d1.rd == 5'(i)))
                    sb[i] <= LAT_INIT;
                else if (sb[i] != '0)
                    sb[i] <= sb[i] - 1'b1;
            end
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pairs   <= '0;
            stat_singles <= '0;
            stat_stalls  <= '0;
        end else if (en) begin
            if (issue1 && stat_pairs != '1)
                stat_pairs <= stat_pairs + 1'b1;
            if (issue0 && !issue1 && stat_singles != '1)
                stat_singles <= stat_singles + 1'b1;
            if (freeze1 && !nothing_filled && stat_stalls != '1)
                stat_stalls <= stat_stalls + 1'b1;
        end
    end
`else
    assign stat_pairs   = '0;
    assign stat_singles = '0;
    assign stat_stalls  = '0;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - scoreboard bench for dual_issue_scheduler against a ready-time reference model
module tb_dual_issue_scheduler;

    localparam int LAT  = 2;
    localparam int DUAL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        nothing_filled = 1'b1;
    logic [31:0] instruction0 = '0;
    logic [31:0] instruction1 = '0;
    logic        ex_stall = 1'b0;
    logic        freeze1, freeze2, dependency_on_ins2;
    logic        issue0_valid, issue1_valid;
    logic [31:0] issue0_instr, issue1_instr;
    logic [31:0] stat_pairs, stat_singles, stat_stalls;

    dual_issue_scheduler #(.LOAD_LAT(LAT), .DUAL_ISSUE(DUAL)) dut (
        .clk(clk), .rst(rst), .en(en), .nothing_filled(nothing_filled),
        .instruction0(instruction0), .instruction1(instruction1), .ex_stall(ex_stall),
        .freeze1(freeze1), .freeze2(freeze2), .dependency_on_ins2(dependency_on_ins2),
        .issue0_valid(issue0_valid), .issue0_instr(issue0_instr),
        .issue1_valid(issue1_valid), .issue1_instr(issue1_instr),
        .stat_pairs(stat_pairs), .stat_singles(stat_singles), .stat_stalls(stat_stalls)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // model: a register is busy until the en-cycle count reaches its ready time
    int ready_at [32];
    int cyc = 0;
    logic        e_v0 = 0, e_v1 = 0;
    logic [31:0] e_i0 = 0, e_i1 = 0;
    int s_pairs = 0, s_singles = 0, s_stalls = 0;
    logic [65:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void classify(input logic [31:0] w, output logic wr, output logic r1,
                                     output logic r2, output logic ld, output logic lsu,
                                     output logic ctl);
        logic [6:0] op;
        op  = w[6:0];
        wr  = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
        r1  = op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        r2  = op inside {7'h63, 7'h23, 7'h33};
        ld  = (op == 7'h03);
        lsu = (op == 7'h03) || (op == 7'h23);
        ctl = op inside {7'h6F, 7'h67, 7'h63};
    endfunction

    function automatic bit busy(input int r);
        return (r != 0) && (cyc < ready_at[r]);
    endfunction

    task automatic step(input logic t_rst, input logic t_en, input logic t_nf,
                        input logic [31:0] t_i0, input logic [31:0] t_i1, input logic t_st);
        logic wr0, r10, r20, ld0, lsu0, ctl0, wr1, r11, r21, ld1, lsu1, ctl1;
        int rd0, a0, b0, rd1, a1, b1;
        bit s0v, s1v, hz, pb, f1, dep, iss0, iss1;
        rst = t_rst; en = t_en; nothing_filled = t_nf;
        instruction0 = t_i0; instruction1 = t_i1; ex_stall = t_st;
        #1;
        classify(t_i0, wr0, r10, r20, ld0, lsu0, ctl0);
        classify(t_i1, wr1, r11, r21, ld1, lsu1, ctl1);
        rd0 = int'(t_i0[11:7]); a0 = int'(t_i0[19:15]); b0 = int'(t_i0[24:20]);
        rd1 = int'(t_i1[11:7]); a1 = int'(t_i1[19:15]); b1 = int'(t_i1[24:20]);
        s0v = !t_nf && t_i0 != 0;
        s1v = !t_nf && t_i1 != 0;
        hz  = s0v && ((r10 && busy(a0)) || (r20 && busy(b0)));
        pb  = !s1v || DUAL == 0 || ctl0 || (lsu0 && lsu1) ||
              (wr0 && rd0 != 0 && ((r11 && a1 == rd0) || (r21 && b1 == rd0))) ||
              (r11 && busy(a1)) || (r21 && busy(b1));
        f1  = t_st || hz;
        dep = !f1 && s0v && pb;
        if (!t_rst && t_en) begin
            check("freeze1", 32'(freeze1), 32'(f1));
            check("freeze2", 32'(freeze2), 32'(t_st));
            check("dependency_on_ins2", 32'(dependency_on_ins2), 32'(dep));
        end
        if (t_rst) begin
            foreach (ready_at[i]) ready_at[i] = 0;
            e_v0 = 0; e_v1 = 0; e_i0 = 0; e_i1 = 0;
            s_pairs = 0; s_singles = 0; s_stalls = 0;
        end else if (t_en) begin
            cyc++;
            iss0 = !t_st && s0v && !hz;
            iss1 = iss0 && !pb;
            if (!t_st) begin
                e_v0 = iss0; e_v1 = iss1; e_i0 = t_i0; e_i1 = t_i1;
            end
            if (iss0 && ld0 && rd0 != 0) ready_at[rd0] = cyc + LAT;
            if (iss1 && ld1 && rd1 != 0) ready_at[rd1] = cyc + LAT;
            if (iss1) s_pairs++;
            if (iss0 && !iss1) s_singles++;
            if (f1 && !t_nf) s_stalls++;
        end
        exp_q.push_back({e_v0, e_i0, e_v1, e_i1});
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, ra, rb;
        rd = 5'($urandom_range(0, 5));
        ra = 5'($urandom_range(0, 5));
        rb = 5'($urandom_range(0, 5));
        case ($urandom_range(0, 8))
            0: return {12'($urandom), ra, 3'b000, rd, 7'b0010011};
            1: return {7'b0, rb, ra, 3'b000, rd, 7'b0110011};
            2: return {12'($urandom), ra, 3'b010, rd, 7'b0000011};
            3: return {7'b0, rb, ra, 3'b010, 5'd4, 7'b0100011};
            4: return {7'b0, rb, ra, 3'b000, 5'd8, 7'b1100011};
            5: return {20'($urandom), rd, 7'b1101111};
            6: return {12'h0, ra, 3'b000, rd, 7'b1100111};
            7: return {20'($urandom), rd, 7'b0110111};
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [65:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("issue0_valid", 32'(issue0_valid), 32'(e[65]));
                check("issue0_instr", issue0_instr, e[64:33]);
                check("issue1_valid", 32'(issue1_valid), 32'(e[32]));
                check("issue1_instr", issue1_instr, e[31:0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        foreach (ready_at[i]) ready_at[i] = 0;
        @(negedge clk);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("reset_freeze1", 32'(freeze1), 0);
        check("reset_dep", 32'(dependency_on_ins2), 0);
        check("reset_issue0_valid", 32'(issue0_valid), 0);
        check("reset_stat_pairs", stat_pairs, 0);

        step(0, 1, 0, 32'h00500093, 32'h00700113, 0);
        step(0, 1, 0, 32'h00500093, 32'h00108113, 0);
        step(0, 1, 0, 32'h00002183, 32'h00000000, 0);
        repeat (3) step(0, 1, 0, 32'h00318233, 32'h00000000, 0);
        step(0, 1, 0, 32'h00002183, 32'h00402283, 0);
        step(0, 1, 0, 32'h00002003, 32'h00000000, 0);
        step(0, 1, 0, 32'h00000233, 32'h00700113, 0);
        repeat (3) step(0, 1, 0, 32'h00500093, 32'h00700113, 1);
        step(0, 1, 0, 32'h00002183, 32'h00000000, 0);
        step(1, 1, 0, 32'h00318233, 32'h00000000, 0);
        step(0, 1, 0, 32'h00318233, 32'h00000000, 0);

        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0,
                 $urandom_range(0, 9) == 0, rand_instr(), rand_instr(),
                 $urandom_range(0, 9) == 0);
        end

        step(0, 1, 1, 0, 0, 0);
        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
`ifdef SCHED_STATS_EN
        check("stat_pairs", stat_pairs, s_pairs);
        check("stat_singles", stat_singles, s_singles);
        check("stat_stalls", stat_stalls, s_stalls);
`else
        check("stat_pairs", stat_pairs, 0);
        check("stat_singles", stat_singles, 0);
        check("stat_stalls", stat_stalls, 0);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- Issue stage directly downstream of the instruction fetch buffer.
- Takes the two head instructions (slot0, slot1) and decodes RV32I register fields.
- Checks intra-pair hazards, structural hazards and a load-latency scoreboard.
- Drives freeze1/freeze2/dependency_on_ins2 back to the fetch buffer, and registers 0, 1 or 2 instructions into the execute-stage issue register.

Parameters:
- LOAD_LAT, 2, cycles a load destination stays busy after issue (1..7).
- DUAL_ISSUE, 1, 0 forces single issue (dependency_on_ins2 asserted whenever slot0 issues).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- en  input  1  global enable; when low, all state and outputs hold
- nothing_filled  input  1  fetch buffer empty
- instruction0  input  32  slot0 (oldest) instruction
- instruction1  input  32  slot1 instruction
- ex_stall  input  1  execute stage cannot accept a new issue bundle
- freeze1  output  1  fetch buffer must not advance
- freeze2  output  1  fetch PC must hold
- dependency_on_ins2  output  1  only slot0 issues; buffer slides by 1
- issue0_valid  output  1  registered lane0 valid
- issue0_instr  output  32  registered lane0 instruction
- issue1_valid  output  1  registered lane1 valid
- issue1_instr  output  32  registered lane1 instruction
- stat_pairs, stat_singles, stat_stalls  output  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset: all scoreboard counters 0; issue*_valid 0; issue*_instr 0; stat_* 0.
- Combinational outputs follow from reset state: freeze1=0, freeze2=0, dependency_on_ins2=0.
- Decode per slot: rd=[11:7], rs1=[19:15], rs2=[24:20].
- Writes rd: opcodes LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
- Reads rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Reads rs2: BRANCH, STORE, OP.
- Register x0 is never a hazard source or target.
- Slot empty: instruction value 32'h0 or nothing_filled=1.
- Scoreboard: one counter per architectural register, width $clog2(LOAD_LAT+1).
  - Issuing a LOAD with rd!=0 (either lane) loads counter[rd]=LOAD_LAT.
  - Every other nonzero counter decrements by 1 per en cycle.
  - Set wins over decrement on the same register in the same cycle.
  - A register is busy while its counter != 0.
- hz0: slot0 reads a busy register.
- pair_block (slot1 may not issue with slot0) when any of:
  - slot1 reads slot0 rd (rd!=0, slot0 writes);
  - slot1 reads a busy register;
  - both slots are LOAD/STORE (single LSU);
  - slot0 is JAL/JALR/BRANCH;
  - slot1 empty;
  - DUAL_ISSUE=0.
- Output decisions, checked in priority order:
  - freeze2 = ex_stall.
  - freeze1 = ex_stall | hz0 when slot0 is valid; freeze1 = ex_stall when empty.
  - dependency_on_ins2 = !freeze1 & slot0 valid & pair_block.
- Issue register, updated on en:
  - ex_stall=1: hold contents.
  - Otherwise issue0_valid <= slot0 valid & !hz0, and issue1_valid <= that & !pair_block.
  - Instruction fields load the slot contents regardless of valid.
- Latency: one cycle from inputs to issue register.
- A load followed immediately by a dependant in slot0 freezes exactly LOAD_LAT cycles.
- WAW within a pair is allowed; lane1 is architecturally younger.
- Reset mid-operation clears pending loads; there is no replay.

Optional Feature:
- Macro: SCHED_STATS_EN.
- Defined: three 32-bit saturating counters, updated on en.
  - stat_pairs increments when both lanes issue.
  - stat_singles increments when only lane0 issues.
  - stat_stalls increments when freeze1=1 and the buffer is not empty.
- Undefined: stat_* tied to 0 and no counter flops are synthesized.

Decomposition:
- sched_pkg holds the RV32I opcode localparams (OPC_LOAD=7'b0000011 etc.).
- sched_pkg also holds an instr_class_e enum (ALU, LOAD, STORE, CTRL, UPPER, NONE) and a decode_t struct (rd, rs1, rs2, writes_rd, reads_rs1, reads_rs2, cls, valid).
- Sub-module sched_decode: combinational, 32-bit instruction in, decode_t out, instantiated once per slot.
- The scoreboard stays inline.

Test Plan:
- 0x00500093 (addi x1,x0,5) + 0x00700113 (addi x2,x0,7) -> dependency_on_ins2=0, freeze1=0; next cycle both valids 1 with those words.
- 0x00500093 + 0x00108113 (addi x2,x1,1) -> dependency_on_ins2=1; next cycle issue0 only.
- 0x00002183 (lw x3) issued, then 0x00318233 (add x4,x3,x3) in slot0 with LOAD_LAT=2 -> freeze1=1 for exactly 2 cycles, then add issues on lane0.
- 0x00002183 + 0x00402283 (two loads) -> dependency_on_ins2=1; lw x0 (0x00002003) never sets the scoreboard.
- ex_stall=1 for 3 cycles -> freeze1=freeze2=1 and issue outputs hold; rst asserted with pending load -> valids 0 and next dependant issues without stall.
- SCHED_STATS_EN with 4 dual-issue pairs, 2 single issues and 2 stall cycles -> stat_pairs=4, stat_singles=2, stat_stalls=2.
